// File: rtl/mips_if_pkg.sv
// mips_if_pkg: shared types and constants for the instruction-fetch stage (FSM states, NOP word, reset PC, redirect alignment)
package mips_if_pkg;
  typedef enum logic {ISSUE, WAIT} state_t;
  localparam logic [31:0] NOP_DEF = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  function automatic logic [31:0] align_target(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/if_inst_buffer.sv
// if_inst_buffer: one-entry fetched-word buffer; ports clock, reset_n, load (capture d_inst/d_pc4), clear (drop entry), valid, inst, pc4
module if_inst_buffer (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] d_inst,
  input  logic [31:0] d_pc4,
  output logic        valid,
  output logic [31:0] inst,
  output logic [31:0] pc4
);
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      valid <= 1'b0;
      inst <= '0;
      pc4 <= '0;
    end else begin
      valid <= load | (valid & ~clear);
      if (load) begin
        inst <= d_inst;
        pc4 <= d_pc4;
      end
    end
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: IF stage owning the PC, single-outstanding imem requests (imem_req/addr/ready/rvalid/rdata), one-entry buffer to IF/ID (inst, pc_plus4, if_valid), redirects (branch_taken/jump + targets, if_flush), stall via pc_write; IF_PERF_CNT_EN adds stall_cnt/fetch_cnt
module if_fetch_unit
  import mips_if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_INST = NOP_DEF
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        pc_write,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] pc_plus4,
  output logic        if_valid,
  output logic        if_flush
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] fetch_cnt
);
`else
);
`endif
  state_t state, next_state;
  logic [31:0] fetch_pc, req_pc4, target, buf_inst, buf_pc4;
  logic run, kill, redirect, consume, buf_valid, hs, load, in_wait;
  assign redirect = branch_taken | jump;
  assign target = align_target(branch_taken ? branch_target : jump_target);
  assign consume = buf_valid & pc_write & ~redirect;
  assign in_wait = state == WAIT;
  assign hs = imem_req & imem_ready;
  assign load = in_wait & imem_rvalid & ~kill & ~redirect;
  assign if_flush = redirect;
  assign if_valid = buf_valid;
  assign inst = buf_valid ? buf_inst : NOP_INST;
  assign pc_plus4 = buf_valid ? buf_pc4 : 32'd0;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= ISSUE;
      run <= 1'b0;
      fetch_pc <= RESET_PC;
      req_pc4 <= '0;
      kill <= 1'b0;
    end else begin
      state <= next_state;
      run <= 1'b1;
      fetch_pc <= redirect ? target : hs ? fetch_pc + 32'd4 : fetch_pc;
      if (hs) req_pc4 <= fetch_pc + 32'd4;
      kill <= (redirect & (hs | (in_wait & ~imem_rvalid))) | (kill & ~(in_wait & imem_rvalid));
    end
  always_comb next_state = in_wait ? (imem_rvalid ? ISSUE : WAIT) : (hs ? WAIT : ISSUE);
  always_comb begin
    imem_req = run & ~in_wait & (~buf_valid | consume);
    imem_addr = fetch_pc;
  end
  if_inst_buffer u_buf (
    .clock  (clock),
    .reset_n(reset_n),
    .load   (load),
    .clear  (redirect | consume),
    .d_inst (imem_rdata),
    .d_pc4  (req_pc4),
    .valid  (buf_valid),
    .inst   (buf_inst),
    .pc4    (buf_pc4)
  );
`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      stall_cnt <= '0;
      fetch_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + {31'd0, buf_valid & ~pc_write & ~redirect & ~&stall_cnt};
      fetch_cnt <= fetch_cnt + {31'd0, consume & ~&fetch_cnt};
    end
`endif
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed stimulus with a transaction-level fetch model and a variable-latency memory model
module tb_if_fetch_unit;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic pc_write = 1'b1;
  logic branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic jump = 1'b0;
  logic [31:0] jump_target = '0;
  logic imem_req;
  logic [31:0] imem_addr;
  logic imem_ready = 1'b0;
  logic imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] inst, pc_plus4;
  logic if_valid, if_flush;
  int checks = 0, errors = 0;
  int lat = 1;
  bit ready_en = 1'b1, stale = 1'b0;
  bit out_pend = 1'b0, hold = 1'b0;
  int lat_left = 0;
  logic [31:0] pend_addr = '0, exp_issue = '0, exp_cons = '0, prev_inst = '0, prev_pc4 = '0;

  if_fetch_unit dut (
    .clock(clock), .reset_n(reset_n), .pc_write(pc_write),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst(inst), .pc_plus4(pc_plus4), .if_valid(if_valid), .if_flush(if_flush)
  );

  initial forever #5 clock = ~clock;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    logic redir, hs, resp;
    logic [31:0] tgt;
    resp = out_pend && lat_left == 0;
    imem_rvalid = resp || stale;
    imem_rdata = resp ? memf(pend_addr) : 32'hDEAD_BEEF;
    imem_ready = ready_en;
    stale = 1'b0;
    #1;
    if (!reset_n) begin
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_valid", {31'd0, if_valid}, 32'd0);
      chk("rst_inst", inst, 32'd0);
      chk("rst_pc4", pc_plus4, 32'd0);
      exp_issue = 32'd0;
      exp_cons = 32'd0;
      out_pend = 1'b0;
      hold = 1'b0;
    end else begin
      redir = branch_taken | jump;
      tgt = (branch_taken ? branch_target : jump_target) & 32'hFFFF_FFFC;
      chk("flush", {31'd0, if_flush}, {31'd0, redir});
      if (!if_valid) begin
        chk("nop_inst", inst, 32'd0);
        chk("nop_pc4", pc_plus4, 32'd0);
      end else chk("word_data", inst, memf(pc_plus4 - 32'd4));
      if (hold) begin
        chk("hold_valid", {31'd0, if_valid}, 32'd1);
        chk("hold_inst", inst, prev_inst);
        chk("hold_pc4", pc_plus4, prev_pc4);
      end
      if (out_pend) chk("one_outstanding", {31'd0, imem_req}, 32'd0);
      hs = imem_req & imem_ready;
      if (hs) chk("issue_addr", imem_addr, exp_issue);
      if (if_valid & pc_write & ~redir) begin
        chk("consume_pc4", pc_plus4, exp_cons + 32'd4);
        exp_cons = exp_cons + 32'd4;
      end
      if (redir) begin
        exp_issue = tgt;
        exp_cons = tgt;
      end else if (hs) exp_issue = exp_issue + 32'd4;
      hold = if_valid & ~pc_write & ~redir;
      prev_inst = inst;
      prev_pc4 = pc_plus4;
      if (resp) out_pend = 1'b0;
      else if (out_pend) lat_left--;
      if (hs) begin
        out_pend = 1'b1;
        pend_addr = imem_addr;
        lat_left = lat - 1;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic wait_valid(input int max);
    int n = 0;
    while (!if_valid && n < max) begin
      cyc();
      n++;
    end
    checks++;
    if (!if_valid) begin
      errors++;
      $display("FAIL wait_valid: got if_valid 0 expected 1 within %0d cycles", max);
    end
  endtask

  initial begin
    cyc();
    cyc();
    reset_n = 1'b1;
    cyc();
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0);
    wait_valid(10);
    chk("w0_inst", inst, 32'h1357_9BDF);
    chk("w0_pc4", pc_plus4, 32'h4);
    cyc();
    wait_valid(10);
    chk("w1_inst", inst, 32'h1357_9BDB);
    chk("w1_pc4", pc_plus4, 32'h8);
    cyc();
    wait_valid(10);
    pc_write = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("stall_req", {31'd0, imem_req}, 32'd0);
      chk("stall_pc4", pc_plus4, 32'hC);
    end
    pc_write = 1'b1;
    #1;
    chk("release_req", {31'd0, imem_req}, 32'd1);
    chk("release_addr", imem_addr, 32'hC);
    lat = 3;
    cyc();
    wait_valid(10);
    chk("lat3_pc4", pc_plus4, 32'h10);
    cyc();
    branch_taken = 1'b1;
    branch_target = 32'h40;
    #1;
    chk("br_flush", {31'd0, if_flush}, 32'd1);
    cyc();
    branch_taken = 1'b0;
    wait_valid(20);
    chk("br_pc4", pc_plus4, 32'h44);
    chk("br_inst", inst, memf(32'h40));
    branch_taken = 1'b1;
    branch_target = 32'h100;
    jump = 1'b1;
    jump_target = 32'h200;
    cyc();
    branch_taken = 1'b0;
    jump = 1'b0;
    #1;
    chk("both_req", {31'd0, imem_req}, 32'd1);
    chk("both_addr", imem_addr, 32'h100);
    wait_valid(20);
    chk("both_pc4", pc_plus4, 32'h104);
    jump = 1'b1;
    jump_target = 32'h203;
    cyc();
    jump = 1'b0;
    #1;
    chk("jmp_align_addr", imem_addr, 32'h200);
    wait_valid(20);
    chk("jmp_pc4", pc_plus4, 32'h204);
    jump = 1'b1;
    jump_target = 32'hFFFF_FFFF;
    cyc();
    jump = 1'b0;
    #1;
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    wait_valid(20);
    chk("wrap_pc4", pc_plus4, 32'h0);
    chk("wrap_next_req", {31'd0, imem_req}, 32'd1);
    chk("wrap_next_addr", imem_addr, 32'h0);
    cyc();
    cyc();
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_req", {31'd0, imem_req}, 32'd0);
    chk("midrst_valid", {31'd0, if_valid}, 32'd0);
    cyc();
    cyc();
    reset_n = 1'b1;
    stale = 1'b1;
    cyc();
    chk("rst_again_addr", imem_addr, 32'h0);
    wait_valid(20);
    chk("post_rst_pc4", pc_plus4, 32'h4);
    chk("post_rst_inst", inst, 32'h1357_9BDF);
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
